// File: rtl/fp16_add_arbiter.sv
// Round-robin arbiter sharing one pipelined fp16 adder among NUM_REQ requesters.
// Tags follow each operation through the adder; results drain through an in-order response FIFO.
module fp16_add_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned ADD_LAT   = 2,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    output logic                   add_en,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    input  logic [15:0]            add_sum,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_data,
    input  logic                   rsp_ready,
    output logic [15:0]            issue_cnt
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + ADD_LAT + 1);
    localparam logic [ID_W:0]      NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(RSP_DEPTH - 1);

    logic [15:0]       op_a [NUM_REQ];
    logic [15:0]       op_b [NUM_REQ];

    logic [ID_W-1:0]   rr_ptr_q;
    logic [15:0]       issue_cnt_q;
    logic [ADD_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [ADD_LAT];

    logic [ID_W-1:0]   fifo_id_q   [RSP_DEPTH];
    logic [15:0]       fifo_data_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [ID_W-1:0]   hold_id_q;
    logic [15:0]       hold_data_q;

    logic [CNT_W-1:0]  inflight;
    logic              can_issue;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W:0]     scan;
    logic              push;
    logic              pop;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[16*g +: 16];
        assign op_b[g] = req_b[16*g +: 16];
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ADD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_vld_q[i]);
        end
    end

    // Credits cover both the adder pipeline and the FIFO, so a push never finds the FIFO full.
    assign can_issue = rst_n && ((inflight + fifo_cnt_q) < CNT_W'(RSP_DEPTH));

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        if (can_issue) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                scan = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
                if (scan >= NUM_REQ_W) begin
                    scan = scan - NUM_REQ_W;
                end
                if (!gnt_vld && req_valid[scan[ID_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = scan[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        add_en    = gnt_vld;
        add_a     = '0;
        add_b     = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
            add_a             = op_a[gnt_id];
            add_b             = op_b[gnt_id];
        end
    end

    assign push      = tag_vld_q[ADD_LAT-1];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_id    = rsp_valid ? fifo_id_q[rd_ptr_q]   : hold_id_q;
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : hold_data_q;
    assign issue_cnt = issue_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            issue_cnt_q <= '0;
            tag_vld_q   <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            if (gnt_vld) begin
                rr_ptr_q    <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            tag_vld_q[0] <= gnt_vld;
            tag_id_q[0]  <= gnt_id;
            for (int i = 1; i < ADD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            hold_id_q   <= '0;
            hold_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            // Remember the last head shown so rsp_data stays stable once the FIFO drains.
            if (rsp_valid) begin
                hold_id_q   <= fifo_id_q[rd_ptr_q];
                hold_data_q <= fifo_data_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q]   <= tag_id_q[ADD_LAT-1];
            fifo_data_q[wr_ptr_q] <= add_sum;
        end
    end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Self-checking bench for fp16_add_arbiter: a transaction-level model predicts grants and
// responses; an adder stand-in returns a fixed function of the operands after ADD_LAT cycles.
module tb_fp16_add_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int ADD_LAT   = 2;
    localparam int RSP_DEPTH = 4;
    localparam int ID_W      = $clog2(NUM_REQ);

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic                  add_en;
    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic [15:0]           add_sum;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_data;
    logic                  rsp_ready;
    logic [15:0]           issue_cnt;

    logic [15:0] ra [NUM_REQ];
    logic [15:0] rb [NUM_REQ];
    logic [15:0] add_pipe [ADD_LAT];

    int checks   = 0;
    int failures = 0;
    int overflow_events = 0;

    typedef struct {
        int          id;
        logic [15:0] sum;
        int          t;
    } op_t;

    op_t ops[$];
    int  rr, icnt, cyc, last_gnt;
    int  last_id;
    logic [15:0] last_data;

    int                 exp_gnt;
    logic [NUM_REQ-1:0] exp_ready;
    logic [15:0]        exp_a, exp_b;
    logic               exp_rsp_valid;
    int                 exp_id;
    logic [15:0]        exp_data;

    fp16_add_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADD_LAT  (ADD_LAT),
        .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .add_en   (add_en),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .rsp_ready(rsp_ready),
        .issue_cnt(issue_cnt)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_a[16*g +: 16] = ra[g];
        assign req_b[16*g +: 16] = rb[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder stand-in: exact fp16 sums for the directed operand pairs, a fixed mix otherwise.
    function automatic logic [15:0] stub_add(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
        if (a == 16'h4000 && b == 16'h3C00) return 16'h4200;
        if (a == 16'h3C00 && b == 16'hBC00) return 16'h0000;
        return a ^ {b[7:0], b[15:8]} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        add_pipe[0] <= add_en ? stub_add(add_a, add_b) : 16'hDEAD;
        for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_sum = add_pipe[ADD_LAT-1];

    always @(posedge clk) begin
        if (rst_n && dut.push && !dut.pop && int'(dut.fifo_cnt_q) >= RSP_DEPTH)
            overflow_events <= overflow_events + 1;
    end

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        ops.delete();
        rr = 0; icnt = 0; last_id = 0; last_data = '0; last_gnt = -1;
    endtask

    // Expected combinational outputs for the current cycle, from the model state and inputs.
    task automatic model_eval();
        exp_gnt = -1;
        if (rst_n && ops.size() < RSP_DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (rr + k) % NUM_REQ;
                if (exp_gnt < 0 && req_valid[i]) exp_gnt = i;
            end
        end
        exp_ready = (exp_gnt >= 0) ? (NUM_REQ'(1) << exp_gnt) : '0;
        exp_a = (exp_gnt >= 0) ? ra[exp_gnt] : 16'h0;
        exp_b = (exp_gnt >= 0) ? rb[exp_gnt] : 16'h0;
        exp_rsp_valid = rst_n && ops.size() > 0 && cyc >= ops[0].t + ADD_LAT + 1;
        exp_id   = exp_rsp_valid ? ops[0].id  : last_id;
        exp_data = exp_rsp_valid ? ops[0].sum : last_data;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        op_t o;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (exp_rsp_valid) begin
                last_id = exp_id; last_data = exp_data;
                if (rsp_ready) void'(ops.pop_front());
            end
            last_gnt = exp_gnt;
            if (exp_gnt >= 0) begin
                o.id = exp_gnt; o.sum = stub_add(ra[exp_gnt], rb[exp_gnt]); o.t = cyc;
                ops.push_back(o);
                rr   = (exp_gnt + 1) % NUM_REQ;
                icnt = (icnt + 1) % 65536;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        model_clear();
        advance();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic refill(input int prob);
        if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
        last_gnt = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(99) < prob) begin
                req_valid[i] = 1'b1;
                ra[i] = 16'($urandom);
                rb[i] = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
        req_valid = '1;
        rsp_ready = 1'b1;
        sample();
        checks += 8;
        if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready: got %0h expected 0", req_ready); end
        if (add_en !== 1'b0)  begin failures++; $display("FAIL reset_add_en: got %0h expected 0", add_en); end
        if (add_a !== 16'h0)  begin failures++; $display("FAIL reset_add_a: got %0h expected 0", add_a); end
        if (add_b !== 16'h0)  begin failures++; $display("FAIL reset_add_b: got %0h expected 0", add_b); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
        if (rsp_id !== '0)    begin failures++; $display("FAIL reset_rsp_id: got %0h expected 0", rsp_id); end
        if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data); end
        if (issue_cnt !== 16'h0) begin failures++; $display("FAIL reset_issue_cnt: got %0h expected 0", issue_cnt); end
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        rsp_ready = 1'b1;
        ra[0] = 16'h3C00; rb[0] = 16'h4000;
        req_valid = 4'b0001;
        sample();
        checks += 4;
        if (add_en !== 1'b1) begin failures++; $display("FAIL single_add_en: got %0h expected 1", add_en); end
        if (add_a !== 16'h3C00) begin failures++; $display("FAIL single_add_a: got %0h expected 3c00", add_a); end
        if (add_b !== 16'h4000) begin failures++; $display("FAIL single_add_b: got %0h expected 4000", add_b); end
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready: got %0h expected 1", req_ready); end
        advance();
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            sample();
            if (k < 3) begin
                checks++;
                if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_rsp: cycle T+%0d got %0h expected 0", k, rsp_valid); end
            end else begin
                checks += 3;
                if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_rsp_valid: got %0h expected 1", rsp_valid); end
                if (rsp_id !== '0) begin failures++; $display("FAIL single_rsp_id: got %0h expected 0", rsp_id); end
                if (rsp_data !== 16'h4200) begin failures++; $display("FAIL single_rsp_data: got %0h expected 4200", rsp_data); end
            end
            advance();
        end
    endtask

    task automatic test_fairness();
        int got[$];
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
        req_valid = '1;
        for (int c = 0; c < 40 && got.size() < 12; c++) begin
            sample();
            checks++;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL fair_ready: got %0h expected %0h", req_ready, exp_ready); end
            if (add_en === 1'b1) got.push_back(onehot_idx(req_ready));
            advance();
        end
        checks++;
        if (got.size() != 12) begin failures++; $display("FAIL fair_grant_count: got %0d expected 12", got.size()); end
        for (int j = 0; j < got.size(); j++) begin
            checks++;
            if (got[j] != j % 4) begin failures++; $display("FAIL fair_order[%0d]: got %0d expected %0d", j, got[j], j % 4); end
        end
        sample();
        checks++;
        if (issue_cnt !== 16'd12) begin failures++; $display("FAIL fair_issue_cnt: got %0d expected 12", issue_cnt); end
    endtask

    task automatic test_skip_wrap();
        logic [NUM_REQ-1:0] seq [3];
        seq[0] = 4'b1000; seq[1] = 4'b0010; seq[2] = 4'b1000;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 4'b0010;
        sample();
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL skip_setup: got %0h expected 2", req_ready); end
        advance();
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            sample();
            checks += 2;
            if (req_ready !== seq[k]) begin failures++; $display("FAIL skip_grant[%0d]: got %0h expected %0h", k, req_ready, seq[k]); end
            if (req_ready !== exp_ready) begin failures++; $display("FAIL skip_model[%0d]: got %0h expected %0h", k, req_ready, exp_ready); end
            advance();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            sample();
            checks++;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL bp_ready: got %0h expected %0h", req_ready, exp_ready); end
            if (add_en === 1'b1) n++;
            advance();
        end
        checks++;
        if (n != RSP_DEPTH) begin failures++; $display("FAIL bp_issue_count: got %0d expected %0d", n, RSP_DEPTH); end
        rsp_ready = 1'b1;
        sample();
        checks += 3;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_full_valid: got %0h expected 1", rsp_valid); end
        if (req_ready !== '0) begin failures++; $display("FAIL bp_pop_cycle_ready: got %0h expected 0", req_ready); end
        if (rsp_data !== exp_data) begin failures++; $display("FAIL bp_head_data: got %0h expected %0h", rsp_data, exp_data); end
        advance();
        rsp_ready = 1'b0;
        sample();
        checks++;
        if (add_en !== 1'b1) begin failures++; $display("FAIL bp_resume: got %0h expected 1", add_en); end
        advance();
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (add_en !== 1'b0) begin failures++; $display("FAIL bp_extra_issue: got %0h expected 0", add_en); end
            advance();
        end
        sample();
        checks += 2;
        if (issue_cnt !== 16'd5) begin failures++; $display("FAIL bp_issue_cnt: got %0d expected 5", issue_cnt); end
        if (overflow_events != 0) begin failures++; $display("FAIL bp_overflow: got %0d expected 0", overflow_events); end
    endtask

    task automatic test_stream();
        bit seen = 1'b0;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 16'h3C00; rb[i] = 16'hBC00; end
        req_valid = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            sample();
            checks += 2;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL stream_ready: got %0h expected %0h", req_ready, exp_ready); end
            if (rsp_valid !== exp_rsp_valid) begin failures++; $display("FAIL stream_valid: got %0h expected %0h", rsp_valid, exp_rsp_valid); end
            if (seen) begin
                checks++;
                if (rsp_valid !== 1'b1) begin failures++; $display("FAIL stream_gap: got %0h expected 1", rsp_valid); end
            end
            if (rsp_valid === 1'b1) begin
                checks += 2;
                if (rsp_data !== 16'h0000) begin failures++; $display("FAIL stream_data: got %0h expected 0", rsp_data); end
                if (rsp_id !== ID_W'(exp_id)) begin failures++; $display("FAIL stream_id: got %0d expected %0d", rsp_id, exp_id); end
                seen = 1'b1;
            end
            advance();
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL stream_no_rsp: got 0 expected 1"); end
        req_valid = '0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 16'($urandom); rb[i] = 16'($urandom); end
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin sample(); advance(); end
        rst_n = 1'b0;
        model_clear();
        sample();
        checks += 7;
        if (req_ready !== '0) begin failures++; $display("FAIL midrst_req_ready: got %0h expected 0", req_ready); end
        if (add_en !== 1'b0) begin failures++; $display("FAIL midrst_add_en: got %0h expected 0", add_en); end
        if (add_a !== 16'h0 || add_b !== 16'h0) begin failures++; $display("FAIL midrst_add_ops: got %0h/%0h expected 0/0", add_a, add_b); end
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid: got %0h expected 0", rsp_valid); end
        if (rsp_id !== '0) begin failures++; $display("FAIL midrst_rsp_id: got %0h expected 0", rsp_id); end
        if (rsp_data !== 16'h0) begin failures++; $display("FAIL midrst_rsp_data: got %0h expected 0", rsp_data); end
        if (issue_cnt !== 16'h0) begin failures++; $display("FAIL midrst_issue_cnt: got %0h expected 0", issue_cnt); end
        advance();
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < ADD_LAT + 4; c++) begin
            sample();
            checks++;
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale_rsp: got %0h expected 0", rsp_valid); end
            advance();
        end
        sample();
        checks++;
        if (issue_cnt !== 16'h0) begin failures++; $display("FAIL midrst_cnt_after: got %0d expected 0", issue_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            refill(40);
            rsp_ready = ($urandom_range(3) != 0);
            sample();
            checks += 8;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready: cyc %0d got %0h expected %0h", cyc, req_ready, exp_ready); end
            if (add_en !== (exp_gnt >= 0)) begin failures++; $display("FAIL rnd_add_en: cyc %0d got %0h expected %0h", cyc, add_en, exp_gnt >= 0); end
            if (add_a !== exp_a) begin failures++; $display("FAIL rnd_add_a: cyc %0d got %0h expected %0h", cyc, add_a, exp_a); end
            if (add_b !== exp_b) begin failures++; $display("FAIL rnd_add_b: cyc %0d got %0h expected %0h", cyc, add_b, exp_b); end
            if (rsp_valid !== exp_rsp_valid) begin failures++; $display("FAIL rnd_rsp_valid: cyc %0d got %0h expected %0h", cyc, rsp_valid, exp_rsp_valid); end
            if (rsp_id !== ID_W'(exp_id)) begin failures++; $display("FAIL rnd_rsp_id: cyc %0d got %0d expected %0d", cyc, rsp_id, exp_id); end
            if (rsp_data !== exp_data) begin failures++; $display("FAIL rnd_rsp_data: cyc %0d got %0h expected %0h", cyc, rsp_data, exp_data); end
            if (issue_cnt !== 16'(icnt)) begin failures++; $display("FAIL rnd_issue_cnt: cyc %0d got %0d expected %0d", cyc, issue_cnt, icnt); end
            advance();
        end
        checks++;
        if (overflow_events != 0) begin failures++; $display("FAIL rnd_overflow: got %0d expected 0", overflow_events); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        cyc = 0;
        for (int i = 0; i < NUM_REQ; i++) begin ra[i] = '0; rb[i] = '0; end
        model_clear();
        test_reset();
        test_single();
        test_fairness();
        test_skip_wrap();
        test_backpressure();
        test_stream();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
